// File: rtl/accel_spi_shift_engine_if.sv
// Controller-side handshake between the accelerometer command controller and the SPI shift engine.
// The master is the controller and the slave is the shift engine.
interface accel_spi_shift_engine_if #(
  parameter int unsigned TX_WIDTH = 16,
  parameter int unsigned RX_WIDTH = 8
);
  logic [TX_WIDTH-1:0] data_tx;
  logic                start;
  logic                done;
  logic                busy;
  logic [RX_WIDTH-1:0] data_rx;

  modport master (
    output data_tx,
    output start,
    input  done,
    input  busy,
    input  data_rx
  );

  modport slave (
    input  data_tx,
    input  start,
    output done,
    output busy,
    output data_rx
  );
endinterface

// File: rtl/accel_spi_shift_engine.sv
// SPI mode-3 master for the ADXL345. It shifts one command word MSB-first while chip select is
// low, captures the trailing read-back byte, and reports completion with a done/start handshake.
module accel_spi_shift_engine #(
  parameter int unsigned TX_WIDTH = 16,
  parameter int unsigned RX_WIDTH = 8,
  parameter int unsigned CS_SETUP = 1,
  parameter int unsigned CS_HOLD  = 1
) (
  input  logic                    spi_clk,
  input  logic                    reset_n,
  input  logic                    spi_clk_out,
  accel_spi_shift_engine_if.slave ctrl,
  output logic                    SPI_SDI,
  input  logic                    SPI_SDO,
  output logic                    SPI_CSN,
  output logic                    SPI_CLK_1
);

  localparam int unsigned CntMax = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned BitW   = (TX_WIDTH > 1) ? $clog2(TX_WIDTH) : 1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StShift = 3'd2,
    StHold  = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [TX_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [RX_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [RX_WIDTH-1:0] data_rx_q, data_rx_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                csn_q, csn_d;
  logic                clk_en_q, clk_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cnt_zero;
  logic                bit_zero;
  logic                rx_window;

  assign cnt_zero  = (cnt_q == '0);
  assign bit_zero  = (bit_cnt_q == '0);
  // Only the trailing RX_WIDTH bits of the frame carry read-back data.
  assign rx_window = (32'(bit_cnt_q) < RX_WIDTH);

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (ctrl.start) state_d = StSetup;
      StSetup: if (cnt_zero) state_d = StShift;
      StShift: if (bit_zero) state_d = StHold;
      StHold:  if (cnt_zero) state_d = StDone;
      StDone:  if (!ctrl.start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    data_rx_d  = data_rx_q;
    bit_cnt_d  = bit_cnt_q;
    cnt_d      = cnt_q;
    csn_d      = csn_q;
    clk_en_d   = clk_en_q;
    busy_d     = busy_q;
    done_d     = done_q;
    case (state_q)
      StIdle: begin
        if (ctrl.start) begin
          tx_shift_d = ctrl.data_tx;
          csn_d      = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = CntW'(CS_SETUP - 1);
        end
      end
      StSetup: begin
        if (cnt_zero) begin
          clk_en_d  = 1'b1;
          bit_cnt_d = BitW'(TX_WIDTH - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StShift: begin
        tx_shift_d = tx_shift_q << 1;
        bit_cnt_d  = bit_cnt_q - 1'b1;
        if (rx_window) rx_shift_d = {rx_shift_q[RX_WIDTH-2:0], SPI_SDO};
        if (bit_zero) begin
          clk_en_d = 1'b0;
          cnt_d    = CntW'(CS_HOLD - 1);
        end
      end
      StHold: begin
        if (cnt_zero) begin
          csn_d     = 1'b1;
          data_rx_d = rx_shift_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (!ctrl.start) done_d = 1'b0;
      end
      default: begin
        csn_d    = 1'b1;
        clk_en_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      data_rx_q  <= '0;
      bit_cnt_q  <= '0;
      cnt_q      <= '0;
      csn_q      <= 1'b1;
      clk_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      data_rx_q  <= data_rx_d;
      bit_cnt_q  <= bit_cnt_d;
      cnt_q      <= cnt_d;
      csn_q      <= csn_d;
      clk_en_q   <= clk_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // The gate opens and closes while spi_clk_out is high, so only whole pulses reach the device.
  assign SPI_CLK_1 = clk_en_q ? spi_clk_out : 1'b1;
  assign SPI_SDI   = (state_q inside {StSetup, StShift, StHold}) ? tx_shift_q[TX_WIDTH-1] : 1'b0;
  assign SPI_CSN   = csn_q;

  assign ctrl.done    = done_q;
  assign ctrl.busy    = busy_q;
  assign ctrl.data_rx = data_rx_q;

endmodule

// File: tb/tb_accel_spi_shift_engine.sv
// Randomised bench for accel_spi_shift_engine: a default instance and a CS_SETUP=3/CS_HOLD=2
// instance, each checked against a device-side model of the frame on the SPI pins.
module tb_accel_spi_shift_engine;

  localparam int TxW    = 16;
  localparam int RxW    = 8;
  localparam int Period = 20;

  logic spi_clk;
  logic spi_clk_out;
  logic reset_n;

  logic [1:0]     start_v;
  logic [TxW-1:0] data_v    [2];
  logic [RxW-1:0] rx_byte_v [2];
  logic [RxW-1:0] exp_rx    [2];

  logic sdi0, sdi1, csn0, csn1, clk10, clk11, sdo0, sdo1;
  logic [1:0] sdi_v, csn_v, clk1_v, done_v, busy_v;

  int n_chk;
  int n_pass;

  accel_spi_shift_engine_if #(.TX_WIDTH(TxW), .RX_WIDTH(RxW)) ctrl0 ();
  accel_spi_shift_engine_if #(.TX_WIDTH(TxW), .RX_WIDTH(RxW)) ctrl1 ();

  assign sdi_v  = {sdi1, sdi0};
  assign csn_v  = {csn1, csn0};
  assign clk1_v = {clk11, clk10};
  assign done_v = {ctrl1.done, ctrl0.done};
  assign busy_v = {ctrl1.busy, ctrl0.busy};
  assign ctrl0.start   = start_v[0];
  assign ctrl1.start   = start_v[1];
  assign ctrl0.data_tx = data_v[0];
  assign ctrl1.data_tx = data_v[1];

  // Device model per instance: records the frame seen on the pins and drives the read byte
  // on SDO after each falling SPI clock of the trailing RxW bits.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    int             pulses;
    int             csn_falls;
    int             gap;
    int             setup_cycles;
    int             low_cycles;
    logic [TxW-1:0] sdi_bits;
    logic           sdo;
    logic           csn_p;
    logic           clk_p;
    bit             first_seen;
    time            t_fall;
    time            t_rise;

    initial begin
      pulses = 0; csn_falls = 0; gap = 1000; setup_cycles = 0; low_cycles = 0;
      sdi_bits = '0; sdo = 1'b0; csn_p = 1'b1; clk_p = 1'b1; first_seen = 1'b0;
      t_fall = 0; t_rise = 0;
    end

    always @(csn_v[g] or clk1_v[g]) begin
      if (csn_p && !csn_v[g]) begin
        gap        = int'((($time - t_rise) / Period));
        t_fall     = $time;
        pulses     = 0;
        sdi_bits   = '0;
        sdo        = 1'b0;
        first_seen = 1'b0;
        csn_falls++;
      end
      if (!csn_p && csn_v[g]) begin
        t_rise     = $time;
        low_cycles = int'(((t_rise - t_fall) / Period));
      end
      if (clk_p && !clk1_v[g]) begin
        if (!first_seen) begin
          setup_cycles = int'((($time - t_fall) / Period));
          first_seen   = 1'b1;
        end
        pulses++;
        sdo = (pulses > TxW - RxW && pulses <= TxW) ? rx_byte_v[g][TxW-pulses] : 1'b0;
      end
      if (!clk_p && clk1_v[g]) sdi_bits = {sdi_bits[TxW-2:0], sdi_v[g]};
      csn_p = csn_v[g];
      clk_p = clk1_v[g];
    end
  end

  assign sdo0 = g_mon[0].sdo;
  assign sdo1 = g_mon[1].sdo;

  accel_spi_shift_engine dut (
    .spi_clk     (spi_clk),
    .reset_n     (reset_n),
    .spi_clk_out (spi_clk_out),
    .ctrl        (ctrl0),
    .SPI_SDI     (sdi0),
    .SPI_SDO     (sdo0),
    .SPI_CSN     (csn0),
    .SPI_CLK_1   (clk10)
  );

  accel_spi_shift_engine #(.CS_SETUP(3), .CS_HOLD(2)) dut_slow (
    .spi_clk     (spi_clk),
    .reset_n     (reset_n),
    .spi_clk_out (spi_clk_out),
    .ctrl        (ctrl1),
    .SPI_SDI     (sdi1),
    .SPI_SDO     (sdo1),
    .SPI_CSN     (csn1),
    .SPI_CLK_1   (clk11)
  );

  initial begin
    spi_clk = 1'b0;
    forever #10 spi_clk = ~spi_clk;
  end

  // Shifted copy of spi_clk: high at each spi_clk rising edge, low from +5 to +15.
  initial begin
    spi_clk_out = 1'b1;
    #15;
    forever begin
      spi_clk_out = 1'b0;
      #10;
      spi_clk_out = 1'b1;
      #10;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic string tg(input string s, input int sel);
    return $sformatf("%s[%0d]", s, sel);
  endfunction

  function automatic int setup_of(input int sel);
    return (sel == 1) ? 3 : 1;
  endfunction

  function automatic int hold_of(input int sel);
    return (sel == 1) ? 2 : 1;
  endfunction

  function automatic logic [RxW-1:0] rx_of(input int sel);
    return (sel == 1) ? ctrl1.data_rx : ctrl0.data_rx;
  endfunction

  function automatic int mon_int(input int sel, input int which);
    case (which)
      0: return (sel == 1) ? g_mon[1].pulses : g_mon[0].pulses;
      1: return (sel == 1) ? g_mon[1].csn_falls : g_mon[0].csn_falls;
      2: return (sel == 1) ? g_mon[1].gap : g_mon[0].gap;
      3: return (sel == 1) ? g_mon[1].setup_cycles : g_mon[0].setup_cycles;
      default: return (sel == 1) ? g_mon[1].low_cycles : g_mon[0].low_cycles;
    endcase
  endfunction

  function automatic logic [TxW-1:0] sdi_bits_of(input int sel);
    return (sel == 1) ? g_mon[1].sdi_bits : g_mon[0].sdi_bits;
  endfunction

  // mode 0: start held past done; 1: controller drops start right after done; 2: start drops
  // mid-frame.
  task automatic run_xfer(input int sel, input logic [TxW-1:0] word, input logic [RxW-1:0] rxb,
                          input int mode);
    int lat;
    int n_done;
    int busy_gaps;
    logic [RxW-1:0] prev_rx;
    lat       = setup_of(sel) + TxW + hold_of(sel);
    prev_rx   = exp_rx[sel];
    n_done    = 0;
    busy_gaps = 0;
    @(negedge spi_clk);
    data_v[sel]    = word;
    rx_byte_v[sel] = rxb;
    start_v[sel]   = 1'b1;
    @(posedge spi_clk); #1;
    check(tg("accept_csn", sel), csn_v[sel], 0);
    check(tg("accept_busy", sel), busy_v[sel], 1);
    check(tg("csn_gap_ge2", sel), mon_int(sel, 2) >= 2, 1);
    data_v[sel] = TxW'($urandom);
    for (int n = 1; n <= lat + 10 && n_done == 0; n++) begin
      @(posedge spi_clk); #1;
      if (mode == 2 && n == 8) start_v[sel] = 1'b0;
      if (n == setup_of(sel) + 8) check(tg("rx_held_mid", sel), rx_of(sel), prev_rx);
      if (done_v[sel]) n_done = n;
      else if (!busy_v[sel]) busy_gaps++;
    end
    check(tg("done_latency", sel), n_done, lat);
    check(tg("busy_gaps", sel), busy_gaps, 0);
    check(tg("busy_at_done", sel), busy_v[sel], 0);
    check(tg("csn_at_done", sel), csn_v[sel], 1);
    check(tg("csn_low_cycles", sel), mon_int(sel, 4), lat);
    check(tg("setup_cycles", sel), mon_int(sel, 3), setup_of(sel));
    check(tg("pulse_count", sel), mon_int(sel, 0), TxW);
    check(tg("sdi_word", sel), sdi_bits_of(sel), word);
    check(tg("data_rx", sel), rx_of(sel), rxb);
    case (mode)
      0: begin
        repeat ($urandom_range(1, 4)) begin
          @(posedge spi_clk); #1;
          check(tg("done_held", sel), done_v[sel], 1);
        end
        start_v[sel] = 1'b0;
        @(posedge spi_clk); #1;
        check(tg("done_drop", sel), done_v[sel], 0);
      end
      1: begin
        start_v[sel] = 1'b0;
        @(posedge spi_clk); #1;
        check(tg("done_drop", sel), done_v[sel], 0);
      end
      default: begin
        @(posedge spi_clk); #1;
        check(tg("done_pulse_1cyc", sel), done_v[sel], 0);
        check(tg("idle_csn", sel), csn_v[sel], 1);
      end
    endcase
    exp_rx[sel] = rxb;
  endtask

  task automatic check_reset_state(input int sel);
    check(tg("rst_csn", sel), csn_v[sel], 1);
    check(tg("rst_clk1", sel), clk1_v[sel], 1);
    check(tg("rst_sdi", sel), sdi_v[sel], 0);
    check(tg("rst_done", sel), done_v[sel], 0);
    check(tg("rst_busy", sel), busy_v[sel], 0);
    check(tg("rst_data_rx", sel), rx_of(sel), 0);
  endtask

  task automatic reset_mid_shift();
    int falls0;
    int falls1;
    @(negedge spi_clk);
    data_v[0]    = 16'hB2AA;
    rx_byte_v[0] = 8'h3C;
    start_v[0]   = 1'b1;
    @(posedge spi_clk);
    // Eight SHIFT edges after the counter loads TxW-1 leaves bit_cnt at 7.
    repeat (setup_of(0) + 8) @(posedge spi_clk);
    #8;
    check("pre_rst_clk1_low", clk1_v[0], 0);
    reset_n = 1'b0;
    #1;
    check_reset_state(0);
    check("rst_data_rx_other", rx_of(1), 0);
    exp_rx[0]  = '0;
    exp_rx[1]  = '0;
    start_v[0] = 1'b0;
    @(negedge spi_clk);
    reset_n = 1'b1;
    falls0  = mon_int(0, 1);
    falls1  = mon_int(1, 1);
    repeat (50) @(posedge spi_clk);
    #1;
    check("quiet_csn_falls[0]", mon_int(0, 1), falls0);
    check("quiet_csn_falls[1]", mon_int(1, 1), falls1);
    check("quiet_done[0]", done_v[0], 0);
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    reset_n = 1'b0;
    start_v = '0;
    for (int i = 0; i < 2; i++) begin
      data_v[i]    = '0;
      rx_byte_v[i] = '0;
      exp_rx[i]    = '0;
    end
    repeat (3) @(posedge spi_clk);
    #1;
    check_reset_state(0);
    check_reset_state(1);
    @(negedge spi_clk);
    reset_n = 1'b1;
    repeat (2) @(posedge spi_clk);

    run_xfer(0, 16'h2420, 8'h00, 0);
    run_xfer(0, 16'hB200, 8'hA5, 1);
    run_xfer(0, 16'h2D08, 8'h00, 1);
    run_xfer(0, TxW'($urandom), RxW'($urandom), 2);
    run_xfer(1, 16'hB200, 8'h5A, 1);
    run_xfer(1, TxW'($urandom), RxW'($urandom), 0);
    reset_mid_shift();

    for (int i = 0; i < 12; i++) begin
      run_xfer(int'($urandom_range(0, 1)), TxW'($urandom), RxW'($urandom),
               int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/accel_spi_shift_engine.md
Name: accel_spi_shift_engine

Overview:
- Bit-level SPI master stage sitting directly below the accelerometer command controller.
- Takes one 16-bit command word per handshake and shifts it MSB-first to the ADXL345 in SPI mode 3 (clock idles high).
- Captures the 8-bit read-back byte, frames the transfer with chip select, and returns done to the controller.

Parameters:
- TX_WIDTH, 16: bits shifted per transaction (address/command byte + data byte).
- RX_WIDTH, 8: trailing bits captured from SPI_SDO into data_rx.
- CS_SETUP, 1: spi_clk cycles CSN is low before the first SPI_CLK_1 pulse; minimum 1.
- CS_HOLD, 1: spi_clk cycles CSN stays low after the last pulse; minimum 1.

Ports:
- spi_clk  in  1  logic and serialiser clock.
- reset_n  in  1  asynchronous, active-low reset.
- spi_clk_out  in  1  phase-shifted copy of spi_clk; gated onto SPI_CLK_1.
- data_tx  in  TX_WIDTH  command word, sampled when a transfer is accepted.
- start  in  1  level request from controller.
- done  out  1  transfer complete; held until start is low.
- busy  out  1  high from acceptance until done rises.
- data_rx  out  RX_WIDTH  last captured read byte.
- SPI_SDI  out  1  serial data to device.
- SPI_SDO  in  1  serial data from device.
- SPI_CSN  out  1  chip select, active low.
- SPI_CLK_1  out  1  gated SPI clock to device.

Behaviour:
- Reset state (asynchronous on reset_n low):
  - SPI_CSN=1, clock gate off (SPI_CLK_1=1), SPI_SDI=0, done=0, busy=0, data_rx=0.
  - State IDLE, shift registers cleared.
- SPI_CLK_1 = clk_en ? spi_clk_out : 1. clk_en is registered on spi_clk posedge. All other logic is on spi_clk posedge only.
- States: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE:
  - On an edge with start=1: load tx_shift<=data_tx, CSN<=0, busy<=1, setup counter<=CS_SETUP-1, go to SETUP.
  - With start=0: stay in IDLE.
- SETUP: count down; when the counter is 0, clk_en<=1, bit_cnt<=TX_WIDTH-1, go to SHIFT.
- SHIFT, one bit per spi_clk edge:
  - tx_shift<=tx_shift<<1.
  - If bit_cnt<RX_WIDTH: rx_shift<={rx_shift[RX_WIDTH-2:0], SPI_SDO}.
  - bit_cnt decrements.
  - When bit_cnt==0: clk_en<=0, go to HOLD.
  - Exactly TX_WIDTH pulses appear on SPI_CLK_1.
- SPI_SDI = tx_shift[TX_WIDTH-1] while in SETUP/SHIFT/HOLD, else 0.
- HOLD:
  - Count CS_HOLD cycles.
  - On the last cycle: CSN<=1, data_rx<=rx_shift (including the bit sampled on the final SHIFT edge), done<=1, busy<=0, go to DONE.
- DONE: when start=0, done<=0 and go to IDLE; otherwise hold done=1.
- Latency: done rises CS_SETUP+TX_WIDTH+CS_HOLD edges after the accepting edge (18 at defaults). CSN is low for that many cycles.
- Back-to-back handshake: the controller drops start for one cycle after seeing done, then re-raises it.
  - The block must drop done on that edge and accept the new start on the next edge.
  - This gives CSN high for at least 2 spi_clk cycles between transfers.
- data_rx is updated on every transfer, including writes; the controller ignores it on writes.
- start falling mid-transfer: ignored. The transfer completes, done is a single-cycle pulse, then the block returns to IDLE.
- data_tx changes after acceptance: no effect until the next acceptance.
- Reset mid-transfer: outputs go immediately to reset values; CSN rises without completing the word; no done is issued.
- Unreachable state encodings recover to IDLE with CSN=1 and clk_en=0.

Test Plan:
- Write 0x2420 with start held high → 16 SPI_CLK_1 pulses; SDI sequence 0010_0100_0010_0000 MSB-first; CSN low 18 cycles; done rises at edge 18, busy low at the same edge.
- Read 0xB200, SDO model drives 0xA5 on the last 8 bits → data_rx=0xA5 when done rises; 0xA5 persists through the following write of 0x2D08.
- Controller-style handshake: start drops for exactly 1 cycle after done, then rises → done low within 1 edge; second transfer accepted; CSN high ≥2 cycles between frames; both words correct.
- reset_n asserted during SHIFT at bit_cnt=7 → CSN=1, SPI_CLK_1=1, done=0 immediately; after release with start=0, no CSN activity for 50 cycles.
- start deasserted during SHIFT → all 16 pulses still issued; done high for exactly 1 cycle; block returns to IDLE.
- CS_SETUP=3, CS_HOLD=2 → first pulse after 3 CSN-low cycles; done at edge 21; pulse count 16.
